// File: rtl/bk_slot_sequencer.sv
// Moves one save slot of 2^SECT_BITS sectors between backup RAM and the hps_io SD sector port.
// Registered outputs; each sector waits for an sd_ack rise then fall, with an optional REQ timeout.
module bk_slot_sequencer #(
    parameter int unsigned       SLOT_BITS   = 2,
    parameter int unsigned       SECT_BITS   = 6,
    parameter int unsigned       LBA_W       = 32,
    parameter logic [LBA_W-1:0]  BASE_LBA    = '0,
    parameter int unsigned       TIMEOUT_CYC = 50000000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 bk_ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    output logic [LBA_W-1:0]     sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic [SECT_BITS-1:0] sect_idx,
    output logic                 busy,
    output logic                 loading,
    output logic                 done,
    output logic                 error
);
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t               state;
    logic                 old_load;
    logic                 old_save;
    logic                 old_ack;
    logic [SLOT_BITS-1:0] slot_q;
    logic [TMO_W-1:0]     tmo_cnt;

    logic                 load_rise;
    logic                 save_rise;
    logic                 ack_rise;
    logic                 ack_fall;
    logic [SECT_BITS-1:0] next_sect;

    assign load_rise = load_req & ~old_load;
    assign save_rise = save_req & ~old_save;
    assign ack_rise  = sd_ack & ~old_ack;
    assign ack_fall  = ~sd_ack & old_ack;
    assign next_sect = sect_idx + SECT_BITS'(1);

    function automatic logic [LBA_W-1:0] lba_of(input logic [SLOT_BITS-1:0] s,
                                                input logic [SECT_BITS-1:0] x);
        return BASE_LBA + LBA_W'({s, x});
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            old_load <= 1'b0;
            old_save <= 1'b0;
            old_ack  <= 1'b0;
            slot_q   <= '0;
            tmo_cnt  <= '0;
            sd_lba   <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            sect_idx <= '0;
            busy     <= 1'b0;
            loading  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // Edge registers track the raw inputs every cycle, so rises seen while busy are lost.
            old_load <= load_req;
            old_save <= save_req;
            old_ack  <= sd_ack;
            done     <= 1'b0;
            error    <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (bk_ena && (load_rise || save_rise)) begin
                        slot_q   <= slot;
                        sect_idx <= '0;
                        loading  <= load_rise;
                        busy     <= 1'b1;
                        sd_rd    <= load_rise;
                        sd_wr    <= ~load_rise;
                        sd_lba   <= lba_of(slot, '0);
                        tmo_cnt  <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_rise) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_XFER;
                    end else if (TIMEOUT_CYC != 0) begin
                        if (tmo_cnt == TMO_LAST) begin
                            sd_rd   <= 1'b0;
                            sd_wr   <= 1'b0;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            loading <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                end
                S_XFER: begin
                    if (ack_fall) begin
                        if (&sect_idx) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            loading <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            sect_idx <= next_sect;
                            sd_lba   <= lba_of(slot_q, next_sect);
                            sd_rd    <= loading;
                            sd_wr    <= ~loading;
                            state    <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
